wb_regfile: RTL

- Architectural integer register file for the pipelined RV32I core. It is the receiving end of the writeback interface: it consumes RegWrite, rd and WD3 from the writeback stage.
- Provides two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Exports a registered debug copy of one register and a retired-write counter for testbench and display use.

---
 rtl/wb_regfile.sv | 70 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - RV32I architectural register file with write-to-read bypass
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEBUG_REG  = 10,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  RegWrite_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0] WD3_i,
  input  logic [ADDR_WIDTH-1:0] A1_i,
  input  logic [ADDR_WIDTH-1:0] A2_i,
  output logic [DATA_WIDTH-1:0] RD1_o,
  output logic [DATA_WIDTH-1:0] RD2_o,
  output logic [DATA_WIDTH-1:0] dbg_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic                  wr_en;

  // x0 writes are dropped here, so regs[0] never leaves its reset value.
  assign wr_en = RegWrite_i && (rd_i != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      dbg_o    <= '0;
      wr_cnt_o <= '0;
    end else if (wr_en) begin
      regs[rd_i] <= WD3_i;
      wr_cnt_o   <= wr_cnt_o + CNT_ONE;
      if (rd_i == DBG_IDX) begin
        dbg_o <= WD3_i;
      end
    end
  end

  // Bypass is gated by reset so every index reads 0 while reset is held.
  always_comb begin
    RD1_o = '0;
    if (rst_n_i && (A1_i != '0)) begin
      if (RegWrite_i && (rd_i == A1_i)) begin
        RD1_o = WD3_i;
      end else begin
        RD1_o = regs[A1_i];
      end
    end
  end

  always_comb begin
    RD2_o = '0;
    if (rst_n_i && (A2_i != '0)) begin
      if (RegWrite_i && (rd_i == A2_i)) begin
        RD2_o = WD3_i;
      end else begin
        RD2_o = regs[A2_i];
      end
    end
  end

endmodule
